// File: rtl/systolic_array_stream.sv
// Rectangular ROWS x COLS output-stationary MAC array. Operands arrive as plain row/column
// beats and are skewed internally. Results drain row by row under valid/ready.
module systolic_array_stream #(
    parameter int DATAWIDTH = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACCW      = 2*DATAWIDTH+8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_last,
    input  logic [ROWS*DATAWIDTH-1:0]              a_col,
    input  logic [COLS*DATAWIDTH-1:0]              b_row,
    input  logic                                   signed_mode,
    input  logic                                   acc_en,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COLS*ACCW-1:0]                   out_row,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
    output logic                                   out_last,
    output logic                                   busy
);
    localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNTW = $clog2(ROWS + COLS);
    localparam int PW   = (ACCW > 2*DATAWIDTH+2) ? ACCW : 2*DATAWIDTH+2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]             r_state, w_next_state;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_in_ready, r_busy, r_signed, r_acc_en;
    logic                   r_out_valid, r_out_last;
    logic [IDXW-1:0]        r_out_row_idx, w_sel_idx;
    logic [COLS*ACCW-1:0]   r_out_row, w_sel_row;
    logic                   w_accept, w_first, w_flush_done, w_out_hs, w_sel_last;

    logic [ROWS-1:0][DATAWIDTH-1:0]            w_sa_d;
    logic [ROWS-1:0]                           w_sa_v, w_sa_f;
    logic [COLS-1:0][DATAWIDTH-1:0]            w_sb_d;
    logic [COLS-1:0]                           w_sb_v;
    logic [ROWS-1:0][COLS-1:0][DATAWIDTH-1:0]  w_a_in, w_b_in, r_pa, r_pb;
    logic [ROWS-1:0][COLS-1:0]                 w_av_in, w_af_in, w_bv_in, r_pav, r_paf, r_pbv;
    logic [ROWS-1:0][COLS-1:0][ACCW-1:0]       r_acc;

    // Full product, sign- or zero-extended, reduced modulo 2^ACCW.
    function automatic logic [ACCW-1:0] f_mul(input logic [DATAWIDTH-1:0] a,
                                              input logic [DATAWIDTH-1:0] b,
                                              input logic sm);
        logic [PW-1:0] ax, bx, px;
        ax = {{(PW-DATAWIDTH){sm & a[DATAWIDTH-1]}}, a};
        bx = {{(PW-DATAWIDTH){sm & b[DATAWIDTH-1]}}, b};
        px = ax * bx;
        return px[ACCW-1:0];
    endfunction

    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign out_valid   = r_out_valid;
    assign out_row     = r_out_row;
    assign out_row_idx = r_out_row_idx;
    assign out_last    = r_out_last;

    assign w_accept     = in_valid & r_in_ready;
    assign w_first      = w_accept & (r_state == S_IDLE);
    assign w_out_hs     = r_out_valid & out_ready;
    assign w_flush_done = (r_state == S_FLUSH) && (r_cnt == CNTW'(ROWS + COLS - 1));

    // A lane i is delayed i cycles; lane 0 feeds the first PE register directly.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign w_sa_d[gi] = w_accept ? a_col[gi*DATAWIDTH +: DATAWIDTH] : {DATAWIDTH{1'b0}};
            assign w_sa_v[gi] = w_accept;
            assign w_sa_f[gi] = w_first;
        end else begin : g_delay
            logic [DATAWIDTH-1:0] r_d [gi];
            logic [gi-1:0]        r_v, r_f;
            // Shift register carrying data, valid and first flag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) r_d[d] <= {DATAWIDTH{1'b0}};
                    r_v <= '0;
                    r_f <= '0;
                end else begin
                    r_d[0] <= w_accept ? a_col[gi*DATAWIDTH +: DATAWIDTH] : {DATAWIDTH{1'b0}};
                    r_v[0] <= w_accept;
                    r_f[0] <= w_first;
                    for (int d = 1; d < gi; d++) begin
                        r_d[d] <= r_d[d-1];
                        r_v[d] <= r_v[d-1];
                        r_f[d] <= r_f[d-1];
                    end
                end
            end
            assign w_sa_d[gi] = r_d[gi-1];
            assign w_sa_v[gi] = r_v[gi-1];
            assign w_sa_f[gi] = r_f[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign w_sb_d[gj] = w_accept ? b_row[gj*DATAWIDTH +: DATAWIDTH] : {DATAWIDTH{1'b0}};
            assign w_sb_v[gj] = w_accept;
        end else begin : g_delay
            logic [DATAWIDTH-1:0] r_d [gj];
            logic [gj-1:0]        r_v;
            // Shift register carrying data and valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < gj; d++) r_d[d] <= {DATAWIDTH{1'b0}};
                    r_v <= '0;
                end else begin
                    r_d[0] <= w_accept ? b_row[gj*DATAWIDTH +: DATAWIDTH] : {DATAWIDTH{1'b0}};
                    r_v[0] <= w_accept;
                    for (int d = 1; d < gj; d++) begin
                        r_d[d] <= r_d[d-1];
                        r_v[d] <= r_v[d-1];
                    end
                end
            end
            assign w_sb_d[gj] = r_d[gj-1];
            assign w_sb_v[gj] = r_v[gj-1];
        end
    end

    // A flows right along PE rows, B flows down PE columns.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            if (gj == 0) begin : g_aleft
                assign w_a_in[gi][gj]  = w_sa_d[gi];
                assign w_av_in[gi][gj] = w_sa_v[gi];
                assign w_af_in[gi][gj] = w_sa_f[gi];
            end else begin : g_ahop
                assign w_a_in[gi][gj]  = r_pa[gi][gj-1];
                assign w_av_in[gi][gj] = r_pav[gi][gj-1];
                assign w_af_in[gi][gj] = r_paf[gi][gj-1];
            end
            if (gi == 0) begin : g_btop
                assign w_b_in[gi][gj]  = w_sb_d[gj];
                assign w_bv_in[gi][gj] = w_sb_v[gj];
            end else begin : g_bhop
                assign w_b_in[gi][gj]  = r_pb[gi-1][gj];
                assign w_bv_in[gi][gj] = r_pbv[gi-1][gj];
            end
        end
    end

    // PE operand registers and accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pa  <= '0;
            r_pb  <= '0;
            r_pav <= '0;
            r_paf <= '0;
            r_pbv <= '0;
            r_acc <= '0;
        end else begin
            r_pa  <= w_a_in;
            r_pb  <= w_b_in;
            r_pav <= w_av_in;
            r_paf <= w_af_in;
            r_pbv <= w_bv_in;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    if (r_pav[i][j] && r_pbv[i][j]) begin
                        if (r_paf[i][j] && !r_acc_en) begin
                            r_acc[i][j] <= f_mul(r_pa[i][j], r_pb[i][j], r_signed);
                        end else begin
                            r_acc[i][j] <= r_acc[i][j] + f_mul(r_pa[i][j], r_pb[i][j], r_signed);
                        end
                    end
                end
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = in_last ? S_FLUSH : S_STREAM;
                else          w_next_state = S_IDLE;
            end
            S_STREAM: begin
                if (w_accept && in_last) w_next_state = S_FLUSH;
                else                     w_next_state = S_STREAM;
            end
            S_FLUSH: begin
                if (w_flush_done) w_next_state = S_DRAIN;
                else              w_next_state = S_FLUSH;
            end
            S_DRAIN: begin
                if (w_out_hs && r_out_last) w_next_state = S_IDLE;
                else                        w_next_state = S_DRAIN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Row to present next: row 0 at end of flush, otherwise the following row.
    always_comb begin
        w_sel_idx = {IDXW{1'b0}};
        if (w_flush_done) w_sel_idx = {IDXW{1'b0}};
        else              w_sel_idx = r_out_row_idx + IDXW'(1);
        w_sel_row  = r_acc[w_sel_idx];
        w_sel_last = (w_sel_idx == IDXW'(ROWS - 1));
    end

    // State, flush counter, status flags and per-matrix mode latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNTW{1'b0}};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_signed   <= 1'b0;
            r_acc_en   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == S_IDLE) || (w_next_state == S_STREAM);
            r_busy     <= (w_next_state != S_IDLE);
            if (r_state == S_FLUSH) r_cnt <= r_cnt + CNTW'(1);
            else                    r_cnt <= {CNTW{1'b0}};
            if (w_first) begin
                r_signed <= signed_mode;
                r_acc_en <= acc_en;
            end
        end
    end

    // Result row register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_row     <= {(COLS*ACCW){1'b0}};
            r_out_row_idx <= {IDXW{1'b0}};
            r_out_last    <= 1'b0;
        end else if (w_flush_done || (w_out_hs && !r_out_last)) begin
            r_out_valid   <= 1'b1;
            r_out_row     <= w_sel_row;
            r_out_row_idx <= w_sel_idx;
            r_out_last    <= w_sel_last;
        end else if (w_out_hs) begin
            r_out_valid   <= 1'b0;
            r_out_row_idx <= {IDXW{1'b0}};
            r_out_last    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench: a 3x3 instance for the square tests and a 2x4 instance for rectangular ones.
module tb_systolic_array_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         v0 = 1'b0, l0 = 1'b0, sm0 = 1'b0, ae0 = 1'b0, or0 = 1'b1;
    logic [47:0]  a0 = '0, b0 = '0;
    logic         ir0, ov0, last0, busy0;
    logic [119:0] row0;
    logic [1:0]   idx0;

    logic         v1 = 1'b0, l1 = 1'b0, sm1 = 1'b0, ae1 = 1'b0, or1 = 1'b1;
    logic [31:0]  a1 = '0;
    logic [63:0]  b1 = '0;
    logic         ir1, ov1, last1, busy1;
    logic [159:0] row1;
    logic [0:0]   idx1;

    systolic_array_stream #(.DATAWIDTH(16), .ROWS(3), .COLS(3), .ACCW(40)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_last(l0),
        .a_col(a0), .b_row(b0), .signed_mode(sm0), .acc_en(ae0),
        .out_valid(ov0), .out_ready(or0), .out_row(row0), .out_row_idx(idx0),
        .out_last(last0), .busy(busy0));

    systolic_array_stream #(.DATAWIDTH(16), .ROWS(2), .COLS(4), .ACCW(40)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_last(l1),
        .a_col(a1), .b_row(b1), .signed_mode(sm1), .acc_en(ae1),
        .out_valid(ov1), .out_ready(or1), .out_row(row1), .out_row_idx(idx1),
        .out_last(last1), .busy(busy1));

    int n_chk = 0;
    int n_bad = 0;

    int A[3][3]  = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    int B[3][3]  = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
    int E1[3][3] = '{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}};
    int E2[3][3] = '{'{60, 48, 36}, '{168, 138, 108}, '{276, 228, 180}};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode inputs are inverted after the first beat; the DUT must ignore that.
    task automatic send3(input int nbeats, input int gap, input logic sm, input logic ae);
        for (int k = 0; k < nbeats; k++) begin
            for (int i = 0; i < 3; i++) begin
                a0[i*16 +: 16] = 16'(A[i][k]);
                b0[i*16 +: 16] = 16'(B[k][i]);
            end
            v0  = 1'b1;
            l0  = (k == 2);
            sm0 = (k == 0) ? sm : ~sm;
            ae0 = (k == 0) ? ae : ~ae;
            @(posedge clk); #1;
            v0 = 1'b0;
            l0 = 1'b0;
            if (k < nbeats - 1) begin
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        a0 = '0;
        b0 = '0;
    endtask

    task automatic send1(input int al[2], input int bl[4], input logic sm);
        for (int i = 0; i < 2; i++) a1[i*16 +: 16] = 16'(al[i]);
        for (int j = 0; j < 4; j++) b1[j*16 +: 16] = 16'(bl[j]);
        v1 = 1'b1; l1 = 1'b1; sm1 = sm; ae1 = 1'b0;
        @(posedge clk); #1;
        v1 = 1'b0; l1 = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int sel, input int lat);
        int n = 0;
        while ((((sel == 0) ? ov0 : ov1) == 1'b0) && (n < 40)) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(n), 64'(lat));
    endtask

    task automatic drain3(input string tag, input int exp[3][3], input int stall_row, input int stall_n);
        for (int r = 0; r < 3; r++) begin
            check({tag, " valid"}, 64'(ov0), 64'(1));
            check({tag, " idx"}, 64'(idx0), 64'(r));
            check({tag, " last"}, 64'(last0), 64'(r == 2));
            for (int j = 0; j < 3; j++)
                check($sformatf("%s r%0d c%0d", tag, r, j), 64'(row0[j*40 +: 40]), {24'd0, 40'(exp[r][j])});
            if (r == stall_row) begin
                or0 = 1'b0; v0 = 1'b1; l0 = 1'b1;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    check({tag, " hold valid"}, 64'(ov0), 64'(1));
                    check({tag, " hold idx"}, 64'(idx0), 64'(r));
                    for (int j = 0; j < 3; j++)
                        check($sformatf("%s hold c%0d", tag, j), 64'(row0[j*40 +: 40]), {24'd0, 40'(exp[r][j])});
                    check({tag, " in_ready drain"}, 64'(ir0), 64'(0));
                end
                v0 = 1'b0; l0 = 1'b0; or0 = 1'b1;
            end
            @(posedge clk); #1;
        end
        check({tag, " end valid"}, 64'(ov0), 64'(0));
        check({tag, " end busy"}, 64'(busy0), 64'(0));
    endtask

    task automatic drain1(input string tag, input int exp[2][4]);
        for (int r = 0; r < 2; r++) begin
            check({tag, " valid"}, 64'(ov1), 64'(1));
            check({tag, " idx"}, 64'(idx1), 64'(r));
            check({tag, " last"}, 64'(last1), 64'(r == 1));
            for (int j = 0; j < 4; j++)
                check($sformatf("%s r%0d c%0d", tag, r, j), 64'(row1[j*40 +: 40]), {24'd0, 40'(exp[r][j])});
            @(posedge clk); #1;
        end
        check({tag, " end valid"}, 64'(ov1), 64'(0));
    endtask

    initial begin
        int al[2];
        int bl[4];
        int e[2][4];

        #1;
        check("rst out_valid", 64'(ov0), 64'(0));
        check("rst busy", 64'(busy0), 64'(0));
        check("rst in_ready", 64'(ir0), 64'(0));
        check("rst idx", 64'(idx0), 64'(0));
        check("rst last", 64'(last0), 64'(0));
        check("rst row", 64'(|row0), 64'(0));
        #20 rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after rst", 64'(ir0), 64'(1));
        check("in_ready after rst b", 64'(ir1), 64'(1));

        send3(3, 0, 1'b1, 1'b0);
        wait_out("t1 latency", 0, 6);
        drain3("t1", E1, -1, 0);

        send3(3, 0, 1'b1, 1'b1);
        wait_out("t3 latency", 0, 6);
        drain3("t3", E2, -1, 0);

        send3(3, 2, 1'b1, 1'b0);
        wait_out("t4 latency", 0, 6);
        drain3("t4", E1, -1, 0);

        send3(3, 0, 1'b0, 1'b0);
        wait_out("t5 latency", 0, 6);
        drain3("t5", E1, 1, 5);

        al = '{-3, 2};
        bl = '{1, -1, 4, 0};
        e  = '{'{-3, 3, -12, 0}, '{2, -2, 8, 0}};
        send1(al, bl, 1'b1);
        wait_out("t2 latency", 1, 6);
        drain1("t2s", e);

        al = '{65535, 0};
        bl = '{2, 0, 0, 0};
        e  = '{'{131070, 0, 0, 0}, '{0, 0, 0, 0}};
        send1(al, bl, 1'b0);
        wait_out("t2u latency", 1, 6);
        drain1("t2u", e);

        e = '{'{-2, 0, 0, 0}, '{0, 0, 0, 0}};
        send1(al, bl, 1'b1);
        wait_out("t2n latency", 1, 6);
        drain1("t2n", e);

        send3(2, 0, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("t6 rst busy", 64'(busy0), 64'(0));
        check("t6 rst in_ready", 64'(ir0), 64'(0));
        check("t6 rst out_valid", 64'(ov0), 64'(0));
        check("t6 rst idx", 64'(idx0), 64'(0));
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6 in_ready", 64'(ir0), 64'(1));
        send3(3, 0, 1'b1, 1'b1);
        wait_out("t6 latency", 0, 6);
        drain3("t6", E1, -1, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
- Parametrised successor of the square systolic array: a rectangular ROWS x COLS output-stationary MAC array.
- Runtime-variable inner dimension K, terminated by in_last.
- Internal input skewing: the producer sends plain column/row beats, not anti-diagonals.
- Per-matrix signed/unsigned mode, optional accumulate-onto-previous-result, and row-by-row result drain with valid/ready backpressure.
- Sits between the operand tile loaders and the result writeback.

Parameters:
DATAWIDTH, 16, operand width in bits
ROWS, 4, PE rows (rows of A and C)
COLS, 4, PE columns (columns of B and C)
ACCW, 2*DATAWIDTH+8, accumulator and output element width; must be >= 2*DATAWIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
in_last  in  1  marks beat K-1 of the current matrix
a_col  in  ROWS*DATAWIDTH  lane i = A[i][k]
b_row  in  COLS*DATAWIDTH  lane j = B[k][j]
signed_mode  in  1  1 = signed operands, 0 = unsigned; sampled on the first beat
acc_en  in  1  1 = add onto held accumulators, 0 = start from zero; sampled on the first beat
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts the row
out_row  out  COLS*ACCW  lane j = C[r][j]
out_row_idx  out  max(1,$clog2(ROWS))  row index r
out_last  out  1  high with row ROWS-1
busy  out  1  state != IDLE

Behaviour:
- Reset values (async on rst): state IDLE, all accumulators, skew and PE registers 0; in_ready 0 while rst high, 1 from the first cycle after release; out_valid 0, out_row 0, out_row_idx 0, out_last 0, busy 0.
- States:
  - IDLE -> STREAM on the first accepted beat.
  - STREAM -> FLUSH on an accepted beat with in_last; a first beat carrying in_last (K=1) goes IDLE -> FLUSH directly.
  - FLUSH -> DRAIN after the flush count.
  - DRAIN -> IDLE when row ROWS-1 handshakes.
- Handshake: beat accepted iff in_valid && in_ready. in_ready = 1 in IDLE/STREAM, 0 in FLUSH/DRAIN.
- Bubbles: in_valid low in STREAM is legal. A zero operand with valid bit 0 enters the skew lines and PEs ignore it.
- Skew:
  - A lane i is delayed i cycles; B lane j is delayed j cycles. Each operand carries a valid bit.
  - A moves right through PE rows, B moves down through PE columns, one register per PE hop.
  - Operands therefore meet in PE(i,j) in matching k order.
- PE(i,j) on a valid operand pair:
  - First product of the matrix with acc_en=0: acc = p.
  - Otherwise: acc = acc + p.
  - A per-beat "first" flag travels with the data to mark the first product.
- Arithmetic: p is the full 2*DATAWIDTH product, signed or unsigned per the latched signed_mode. It is sign- or zero-extended to ACCW; accumulation wraps modulo 2^ACCW with no saturation.
- Latched modes: signed_mode and acc_en are captured on the first beat of a matrix; changes later in the same matrix are ignored.
- Latency:
  - out_valid rises exactly ROWS+COLS cycles after the edge that accepted in_last (FLUSH covers the skew plus PE propagation).
  - With continuous out_ready, one row per cycle, rows 0..ROWS-1 in order.
- Drain:
  - out_row, out_row_idx and out_last are held stable while out_valid && !out_ready.
  - A row advances only on handshake; no row is skipped or duplicated.
  - out_valid drops the cycle after the last handshake.
- Accumulators keep their values after drain, for the next acc_en=1 matrix.
- Reset mid-operation: immediate return to reset values; any partial matrix is discarded and accumulators are cleared.
- in_last offered while in_ready=0 is not accepted and has no effect.

Test Plan:
1. Basic: ROWS=COLS=3, signed, acc_en=0. A=[1 2 3;4 5 6;7 8 9], B=[9 8 7;6 5 4;3 2 1], 3 beats with in_last on beat 2.
   - Rows: [30 24 18], [84 69 54], [138 114 90].
   - out_valid exactly 6 cycles after the in_last edge; out_last on row 2.
2. Rectangular signed: ROWS=2, COLS=4, K=1, a_col=[-3,2], b_row=[1,-1,4,0].
   - Rows: [-3 3 -12 0], [2 -2 8 0].
   - Unsigned variant: a=0xFFFF, b=0x0002 gives 0x1FFFE; the same operands signed give -2.
3. Accumulate: test 1 followed by the same matrix with acc_en=1.
   - Second result: [60 48 36], [168 138 108], [276 228 180].
4. Bubbles: test 1 beats with 2 idle cycles between each.
   - Identical result; out_valid 6 cycles after the in_last edge.
5. Backpressure: out_ready low for 5 cycles while row 1 is presented.
   - Row 1 data and index stable throughout; rows 0, 1, 2 each seen exactly once.
   - in_ready stays 0 during DRAIN; new in_valid is ignored.
6. Reset mid-stream: rst pulsed after 2 beats of test 1.
   - Outputs return to reset values asynchronously.
   - A fresh test-1 matrix sent with acc_en=1 still yields [30 24 18], [84 69 54], [138 114 90].
